shift_merge_ctrl: RTL and testbench
===================================

Name: shift_merge_ctrl

Overview:
Issue controller in front of the shift/merge unit for EXTR, DEP and DSR instructions. It accepts one instruction at a time from the decode stage and holds the architectural shift-amount register (SAR) together with its pending-write scoreboard. It stalls SAR-dependent operations until the SAR write lands, then presents registered shift amount, left position and right position to the shift/merge datapath under a valid/ready handshake.

Parameters:
OP_EXTR, 6'o12, opcode of EXTR
OP_DEP, 6'o13, opcode of DEP
OP_DSR, 6'o14, opcode of DSR
STALL_CNT_W, 8, width of the saturating SAR-stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  instruction offered by decode
in_ready  out  1  controller can accept an instruction this cycle
instr  in  32  instruction word, bit 0 = MSB
sar_pend_set  in  1  earlier pipeline stage has issued a SAR write
sar_wr  in  1  SAR write data valid
sar_wdata  in  5  new SAR value
out_valid  out  1  sa/pl/pr/op_kind valid
out_ready  in  1  shift/merge stage accepts
op_kind  out  2  0=EXTR 1=DEP 2=DSR
sa  out  5  shift amount
pl  out  5  left bit position
pr  out  5  right bit position
illegal  out  1  one-cycle pulse on an unrecognised opcode
stall_cnt  out  STALL_CNT_W  saturating count of cycles spent in WAIT_SAR
sar  out  5  current SAR value

Behaviour:
- Instruction fields: op=instr[0:5], pos=instr[9:13], len=instr[14:18], use_sar=instr[19].
- Reset (rst=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, sa/pl/pr/op_kind=0, illegal=0, sar=0, sar_pend=0, stall_cnt=0. Reset asserted mid-operation discards the held instruction.
- SAR scoreboard:
  - sar_pend_set sets sar_pend.
  - sar_wr loads sar and clears sar_pend.
  - If both occur in the same cycle, sar_wr takes effect and sar_pend stays set.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, capture instr.
    - Bad opcode: pulse illegal for one cycle and stay in IDLE.
    - use_sar=1 and sar_pend=1 (with no sar_wr in the same cycle): go to WAIT_SAR.
    - Otherwise: go to ISSUE.
  - WAIT_SAR: in_ready=0. Increment stall_cnt each cycle, saturating at all-ones. On sar_wr, go to ISSUE using sar_wdata (no extra bubble).
  - ISSUE: compute outputs and register them; out_valid=1 in the next cycle; go to HOLD.
  - HOLD: out_valid=1 and outputs stable until out_ready.
    - On out_ready with in_valid: accept the next instruction in the same cycle (back-to-back).
    - On out_ready without in_valid: go to IDLE.
- in_ready is 1 in IDLE, and in HOLD when out_ready=1. It is 0 otherwise.
- Latency: 2 cycles from acceptance to out_valid when there is no stall.
- Effective amount: amt = use_sar ? sar : len. All arithmetic is 5-bit and wraps modulo 32.
  - EXTR: pr=pos, pl=pos-amt+1, sa=31-pos.
  - DEP: pr=pos, pl=pos-amt+1, sa=31-pos.
  - DSR: sa=amt, pl=0, pr=31.
- Boundaries:
  - pos<amt-1 wraps; no error is raised.
  - amt=0 with EXTR/DEP gives pl=pos+1, meaning an empty field.
  - stall_cnt never wraps.
  - A SAR update while in HOLD does not alter the registered outputs.

Decomposition:
- Package shift_merge_pkg holds:
  - opcode constants;
  - field bit positions;
  - op_kind encoding;
  - state enum (IDLE, WAIT_SAR, ISSUE, HOLD).
- One combinational sub-module, shift_merge_field_calc, computes (op_kind, pos, amt) -> (sa, pl, pr). The FSM, scoreboard and registers stay in the top level.

Test Plan:
- Reset, then EXTR with pos=19, len=10, use_sar=0, out_ready=1 -> out_valid after 2 cycles; sa=12, pl=10, pr=19, op_kind=0.
- sar_wr=1 with sar_wdata=12, then DSR with use_sar=1 -> sa=12, pl=0, pr=31, op_kind=2.
- sar_pend_set, then DEP with pos=31, use_sar=1; sar_wr with sar_wdata=10 after 5 cycles -> stall_cnt=5; outputs sa=0, pl=22, pr=31 on the cycle after ISSUE.
- out_ready held low for 4 cycles with a second in_valid pending -> outputs stable and in_ready=0; on out_ready=1 the second instruction is accepted that same cycle.
- Opcode 6'o77 -> illegal pulses for exactly 1 cycle; out_valid stays 0; in_ready stays 1.
- Assert rst=0 while in WAIT_SAR -> all outputs are zero immediately (asynchronously) and the state is IDLE; sar_wr arriving later does not issue anything.

Source files
------------

// File: rtl/shift_merge_pkg.sv
// Shared definitions for the shift/merge issue controller.
//   - opcode constants for EXTR, DEP and DSR
//   - instruction field locations (the instruction word numbers bit 0 as its MSB)
//   - op_kind encoding presented to the shift/merge datapath
//   - controller state encoding
//   - small decode helpers used by the controller
package shift_merge_pkg;

   localparam logic [5:0] OP_EXTR = 6'o12;
   localparam logic [5:0] OP_DEP  = 6'o13;
   localparam logic [5:0] OP_DSR  = 6'o14;

   // Field LSB positions in [31:0] terms. The architectural numbering is
   // MSB-first, so architectural bit k lives at vector index 31-k.
   localparam int OP_LSB      = 26;  // instr[0:5]
   localparam int POS_LSB     = 18;  // instr[9:13]
   localparam int LEN_LSB     = 13;  // instr[14:18]
   localparam int USE_SAR_BIT = 12;  // instr[19]

   typedef enum logic [1:0] {
      KIND_EXTR = 2'd0,
      KIND_DEP  = 2'd1,
      KIND_DSR  = 2'd2
   } opKind_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SAR,
      ISSUE,
      HOLD
   } state_t;

   typedef struct packed {
      logic [5:0] op;
      logic [4:0] pos;
      logic [4:0] len;
      logic       useSar;
   } instrFields_t;

   function automatic instrFields_t decodeFields(input logic [31:0] word);
      instrFields_t f;
      f.op     = word[OP_LSB +: 6];
      f.pos    = word[POS_LSB +: 5];
      f.len    = word[LEN_LSB +: 5];
      f.useSar = word[USE_SAR_BIT];
      return f;
   endfunction

   function automatic logic isLegalOp(input logic [5:0] op);
      return (op == OP_EXTR) || (op == OP_DEP) || (op == OP_DSR);
   endfunction

   function automatic opKind_t opToKind(input logic [5:0] op);
      case (op)
         OP_DEP:  return KIND_DEP;
         OP_DSR:  return KIND_DSR;
         default: return KIND_EXTR;
      endcase
   endfunction

endpackage

// File: rtl/shift_merge_field_calc.sv
// Combinational field calculator for the shift/merge datapath.
// Ports:
//   opKind  in  2  operation class (EXTR / DEP / DSR)
//   pos     in  5  field position from the instruction
//   amt     in  5  effective amount (SAR or instruction length)
//   sa      out 5  shift amount
//   pl      out 5  left bit position
//   pr      out 5  right bit position
// All arithmetic is 5-bit and wraps modulo 32; a wrapped pl is legal and
// amt=0 yields pl=pos+1, which the datapath reads as an empty field.
module shift_merge_field_calc
   import shift_merge_pkg::*;
(
   input  opKind_t    opKind,
   input  logic [4:0] pos,
   input  logic [4:0] amt,
   output logic [4:0] sa,
   output logic [4:0] pl,
   output logic [4:0] pr
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      sa = '0;
      pl = '0;
      pr = '0;
      case (opKind)
         KIND_EXTR, KIND_DEP: begin
            pr = pos;
            pl = pos - amt + 5'd1;
            sa = 5'd31 - pos;
         end
         KIND_DSR: begin
            sa = amt;
            pl = 5'd0;
            pr = 5'd31;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/shift_merge_ctrl.sv
// Issue controller for EXTR / DEP / DSR in front of the shift/merge unit.
// Holds the architectural SAR and its pending-write scoreboard, stalls
// SAR-dependent instructions until the write lands, then presents registered
// sa/pl/pr/op_kind under a valid/ready handshake.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   instruction handshake from decode
//   instr                 32-bit instruction word (bit 0 = MSB)
//   sar_pend_set          an earlier stage has issued a SAR write
//   sar_wr / sar_wdata    SAR write data
//   out_valid / out_ready result handshake to the shift/merge stage
//   op_kind, sa, pl, pr   registered datapath controls
//   illegal               one-cycle pulse on an unrecognised opcode
//   stall_cnt             saturating count of cycles spent in WAIT_SAR
//   sar                   current SAR value
module shift_merge_ctrl
   import shift_merge_pkg::*;
#(
   parameter int STALL_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            instr,
   input  logic                   sar_pend_set,
   input  logic                   sar_wr,
   input  logic [4:0]             sar_wdata,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [1:0]             op_kind,
   output logic [4:0]             sa,
   output logic [4:0]             pl,
   output logic [4:0]             pr,
   output logic                   illegal,
   output logic [STALL_CNT_W-1:0] stall_cnt,
   output logic [4:0]             sar
);

   localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

   state_t                 state;
   state_t                 acceptState;
   instrFields_t           fields;
   logic                   accept;
   logic                   opLegal;
   logic [4:0]             acceptAmt;

   opKind_t                kindReg;
   logic [4:0]             posReg;
   logic [4:0]             amtReg;
   opKind_t                opKindReg;
   logic [4:0]             saReg;
   logic [4:0]             plReg;
   logic [4:0]             prReg;
   logic [4:0]             calcSa;
   logic [4:0]             calcPl;
   logic [4:0]             calcPr;
   logic [4:0]             sarReg;
   logic                   sarPend;
   logic                   outValidReg;
   logic                   illegalReg;
   logic [STALL_CNT_W-1:0] stallCnt;

   assign fields   = decodeFields(instr);
   assign opLegal  = isLegalOp(fields.op);
   assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
   assign accept   = in_valid && in_ready;

   // The amount is resolved at acceptance; a SAR write landing in the same
   // cycle is forwarded so the instruction never sees a stale SAR.
   always_comb begin
      acceptAmt = fields.useSar ? (sar_wr ? sar_wdata : sarReg) : fields.len;
      if (!opLegal) begin
         acceptState = IDLE;
      end else if (fields.useSar && sarPend && !sar_wr) begin
         acceptState = WAIT_SAR;
      end else begin
         acceptState = ISSUE;
      end
   end

   shift_merge_field_calc u_calc (
      .opKind (kindReg),
      .pos    (posReg),
      .amt    (amtReg),
      .sa     (calcSa),
      .pl     (calcPl),
      .pr     (calcPr)
   );

   // NOTE: all sequential state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         sarReg      <= '0;
         sarPend     <= 1'b0;
         stallCnt    <= '0;
         outValidReg <= 1'b0;
         illegalReg  <= 1'b0;
         // NOTE: the datapath registers are reset as well so every output reads zero while rst is low.
         kindReg     <= KIND_EXTR;
         posReg      <= '0;
         amtReg      <= '0;
         opKindReg   <= KIND_EXTR;
         saReg       <= '0;
         plReg       <= '0;
         prReg       <= '0;
      end else begin
         illegalReg <= 1'b0;

         // Scoreboard: a write wins over a same-cycle set but leaves pend set.
         if (sar_wr) begin
            sarReg  <= sar_wdata;
            sarPend <= sar_pend_set;
         end else if (sar_pend_set) begin
            sarPend <= 1'b1;
         end

         case (state)
            IDLE: ;
            WAIT_SAR: begin
               if (stallCnt != '1) begin
                  stallCnt <= stallCnt + STALL_ONE;
               end
               if (sar_wr) begin
                  amtReg <= sar_wdata;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               opKindReg   <= kindReg;
               saReg       <= calcSa;
               plReg       <= calcPl;
               prReg       <= calcPr;
               outValidReg <= 1'b1;
               state       <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  outValidReg <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Acceptance (IDLE, or HOLD during the output handshake) overrides
         // the HOLD->IDLE step above to give back-to-back issue.
         if (accept) begin
            state      <= acceptState;
            illegalReg <= !opLegal;
            kindReg    <= opToKind(fields.op);
            posReg     <= fields.pos;
            amtReg     <= acceptAmt;
         end
      end
   end

   assign out_valid = outValidReg;
   assign op_kind   = opKindReg;
   assign sa        = saReg;
   assign pl        = plReg;
   assign pr        = prReg;
   assign illegal   = illegalReg;
   assign stall_cnt = stallCnt;
   assign sar       = sarReg;

endmodule

// File: tb/tb_shift_merge_ctrl.sv
module tb_shift_merge_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        sar_pend_set;
   logic        sar_wr;
   logic [4:0]  sar_wdata;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  op_kind;
   logic [4:0]  sa;
   logic [4:0]  pl;
   logic [4:0]  pr;
   logic        illegal;
   logic [7:0]  stall_cnt;
   logic [4:0]  sar;

   int vectors     = 0;
   int miscompares = 0;

   localparam logic [5:0] EXTR = 6'o12;
   localparam logic [5:0] DEP  = 6'o13;
   localparam logic [5:0] DSR  = 6'o14;
   localparam logic [5:0] BAD  = 6'o77;

   localparam logic [32:0] RESET_WANT = {1'b1, 1'b0, 2'd0, 15'd0, 1'b0, 8'd0, 5'd0};

   // Reference-model state for the randomized test
   logic [4:0]  mSar;
   bit          mPend;
   bit          mWaiting;
   bit          mIllegalNext;
   int          inFlight;
   logic [5:0]  wOp;
   logic [4:0]  wPos;
   logic [16:0] expQ[$];

   shift_merge_ctrl #(.STALL_CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .instr        (instr),
      .sar_pend_set (sar_pend_set),
      .sar_wr       (sar_wr),
      .sar_wdata    (sar_wdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .op_kind      (op_kind),
      .sa           (sa),
      .pl           (pl),
      .pr           (pr),
      .illegal      (illegal),
      .stall_cnt    (stall_cnt),
      .sar          (sar)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Instruction words use MSB-first bit numbering: architectural bit k is index 31-k.
   function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [4:0] pos,
                                           input logic [4:0] len, input logic useSar,
                                           input logic [31:0] filler);
      logic [31:0] w;
      w = filler;
      for (int i = 0; i < 6; i++) w[31-i] = op[5-i];
      for (int i = 0; i < 5; i++) w[31-(9+i)] = pos[4-i];
      for (int i = 0; i < 5; i++) w[31-(14+i)] = len[4-i];
      w[31-19] = useSar;
      return w;
   endfunction

   function automatic logic [4:0] field5(input logic [31:0] w, input int first);
      logic [4:0] v;
      for (int i = 0; i < 5; i++) v[4-i] = w[31-(first+i)];
      return v;
   endfunction

   function automatic logic [5:0] opOf(input logic [31:0] w);
      logic [5:0] v;
      for (int i = 0; i < 6; i++) v[5-i] = w[31-i];
      return v;
   endfunction

   // Expected {op_kind, sa, pl, pr} from the instruction rules, plain integer arithmetic
   function automatic logic [16:0] refResult(input logic [5:0] op, input int pos, input int amt);
      int kind, rsa, rpl, rpr;
      kind = (op == DEP) ? 1 : (op == DSR) ? 2 : 0;
      if (kind == 2) begin
         rsa = amt; rpl = 0; rpr = 31;
      end else begin
         rpr = pos;
         rpl = ((pos - amt + 1) % 32 + 32) % 32;
         rsa = 31 - pos;
      end
      return {kind[1:0], rsa[4:0], rpl[4:0], rpr[4:0]};
   endfunction

   task automatic driveIdle();
      in_valid     = 1'b0;
      instr        = '0;
      sar_pend_set = 1'b0;
      sar_wr       = 1'b0;
      sar_wdata    = '0;
      out_ready    = 1'b0;
   endtask

   task automatic applyReset();
      driveIdle();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Bounded wait: returns at negedge+1 with out_valid high, or after the budget expires
   task automatic waitOutValid();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (out_valid === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      driveIdle();
      rst = 1'b0;
      #1;
      vectors++;
      if ({in_ready, out_valid, op_kind, sa, pl, pr, illegal, stall_cnt, sar} !== RESET_WANT)
      begin
         miscompares++;
         $display("FAIL reset_state got %h want %h",
                  {in_ready, out_valid, op_kind, sa, pl, pr, illegal, stall_cnt, sar}, RESET_WANT);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_extr_latency();
      @(negedge clk);
      in_valid  = 1'b1;
      instr     = mkInstr(EXTR, 5'd19, 5'd10, 1'b0, $urandom);
      out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL extr_in_ready got %b want 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL extr_early_valid got %b want 0", out_valid);
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({out_valid, op_kind, sa, pl, pr} !== {1'b1, 2'd0, 5'd12, 5'd10, 5'd19}) begin
         miscompares++;
         $display("FAIL extr_result got v=%b k=%0d sa=%0d pl=%0d pr=%0d want v=1 k=0 sa=12 pl=10 pr=19",
                  out_valid, op_kind, sa, pl, pr);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++; $display("FAIL extr_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
      driveIdle();
   endtask

   task automatic test_dsr_sar();
      @(negedge clk);
      sar_wr    = 1'b1;
      sar_wdata = 5'd12;
      @(negedge clk);
      sar_wr = 1'b0;
      #1;
      vectors++;
      if (sar !== 5'd12) begin
         miscompares++; $display("FAIL dsr_sar_load got %0d want 12", sar);
      end
      in_valid  = 1'b1;
      instr     = mkInstr(DSR, 5'($urandom), 5'($urandom), 1'b1, $urandom);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      waitOutValid();
      vectors++;
      if ({out_valid, op_kind, sa, pl, pr} !== {1'b1, 2'd2, 5'd12, 5'd0, 5'd31}) begin
         miscompares++;
         $display("FAIL dsr_result got v=%b k=%0d sa=%0d pl=%0d pr=%0d want v=1 k=2 sa=12 pl=0 pr=31",
                  out_valid, op_kind, sa, pl, pr);
      end
      @(negedge clk);
      driveIdle();
   endtask

   task automatic test_stall();
      @(negedge clk);
      sar_pend_set = 1'b1;
      @(negedge clk);
      sar_pend_set = 1'b0;
      in_valid     = 1'b1;
      instr        = mkInstr(DEP, 5'd31, 5'd7, 1'b1, $urandom);
      out_ready    = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL stall_wait got rdy=%b v=%b want 0 0", in_ready, out_valid);
         end
         @(negedge clk);
      end
      sar_wr    = 1'b1;
      sar_wdata = 5'd10;
      @(negedge clk);
      sar_wr = 1'b0;
      #1;
      vectors++;
      if ({stall_cnt, sar, out_valid} !== {8'd5, 5'd10, 1'b0}) begin
         miscompares++;
         $display("FAIL stall_count got cnt=%0d sar=%0d v=%b want cnt=5 sar=10 v=0", stall_cnt, sar, out_valid);
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({out_valid, op_kind, sa, pl, pr} !== {1'b1, 2'd1, 5'd0, 5'd22, 5'd31}) begin
         miscompares++;
         $display("FAIL stall_result got v=%b k=%0d sa=%0d pl=%0d pr=%0d want v=1 k=1 sa=0 pl=22 pr=31",
                  out_valid, op_kind, sa, pl, pr);
      end
      @(negedge clk);
      driveIdle();
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      in_valid  = 1'b1;
      instr     = mkInstr(EXTR, 5'd20, 5'd4, 1'b0, $urandom);
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      instr    = mkInstr(DSR, 5'($urandom), 5'd7, 1'b0, $urandom);
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++;
         if ({in_ready, out_valid, op_kind, sa, pl, pr} !== {1'b0, 1'b1, 2'd0, 5'd11, 5'd17, 5'd20}) begin
            miscompares++;
            $display("FAIL b2b_hold got rdy=%b v=%b k=%0d sa=%0d pl=%0d pr=%0d want rdy=0 v=1 k=0 sa=11 pl=17 pr=20",
                     in_ready, out_valid, op_kind, sa, pl, pr);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL b2b_accept got rdy=%b want 1", in_ready);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL b2b_gap got v=%b want 0", out_valid);
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({out_valid, op_kind, sa, pl, pr} !== {1'b1, 2'd2, 5'd7, 5'd0, 5'd31}) begin
         miscompares++;
         $display("FAIL b2b_second got v=%b k=%0d sa=%0d pl=%0d pr=%0d want v=1 k=2 sa=7 pl=0 pr=31",
                  out_valid, op_kind, sa, pl, pr);
      end
      out_ready = 1'b1;
      @(negedge clk);
      driveIdle();
   endtask

   task automatic test_illegal();
      @(negedge clk);
      in_valid  = 1'b1;
      instr     = mkInstr(BAD, 5'($urandom), 5'($urandom), 1'b0, $urandom);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      vectors++;
      if ({illegal, out_valid, in_ready} !== 3'b101) begin
         miscompares++; $display("FAIL illegal_pulse got ill/v/rdy=%b want 101", {illegal, out_valid, in_ready});
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({illegal, out_valid, in_ready} !== 3'b001) begin
         miscompares++; $display("FAIL illegal_clear got ill/v/rdy=%b want 001", {illegal, out_valid, in_ready});
      end
      driveIdle();
   endtask

   task automatic test_boundaries();
      logic [5:0]  bOp[4]   = '{EXTR, DEP, EXTR, DSR};
      logic [4:0]  bPos[4]  = '{5'd5, 5'd3, 5'd0, 5'd9};
      logic [4:0]  bLen[4]  = '{5'd0, 5'd10, 5'd31, 5'd0};
      logic [16:0] bWant[4] = '{{2'd0, 5'd26, 5'd6, 5'd5},
                                {2'd1, 5'd28, 5'd26, 5'd3},
                                {2'd0, 5'd31, 5'd2, 5'd0},
                                {2'd2, 5'd0, 5'd0, 5'd31}};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         instr     = mkInstr(bOp[i], bPos[i], bLen[i], 1'b0, $urandom);
         out_ready = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         waitOutValid();
         vectors++;
         if ({out_valid, op_kind, sa, pl, pr} !== {1'b1, bWant[i]}) begin
            miscompares++;
            $display("FAIL boundary_%0d got v=%b k=%0d sa=%0d pl=%0d pr=%0d want %h",
                     i, out_valid, op_kind, sa, pl, pr, {1'b1, bWant[i]});
         end
         @(negedge clk);
         driveIdle();
      end
   endtask

   task automatic test_hold_sar_update();
      @(negedge clk);
      sar_wr    = 1'b1;
      sar_wdata = 5'd9;
      @(negedge clk);
      sar_wr    = 1'b0;
      in_valid  = 1'b1;
      instr     = mkInstr(DSR, 5'd4, 5'd2, 1'b1, $urandom);
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      waitOutValid();
      sar_wr    = 1'b1;
      sar_wdata = 5'd3;
      @(negedge clk);
      sar_wr = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if ({out_valid, op_kind, sa, pl, pr, sar} !== {1'b1, 2'd2, 5'd9, 5'd0, 5'd31, 5'd3}) begin
         miscompares++;
         $display("FAIL hold_sar got v=%b k=%0d sa=%0d pl=%0d pr=%0d sar=%0d want v=1 k=2 sa=9 pl=0 pr=31 sar=3",
                  out_valid, op_kind, sa, pl, pr, sar);
      end
      out_ready = 1'b1;
      @(negedge clk);
      driveIdle();
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      sar_pend_set = 1'b1;
      @(negedge clk);
      sar_pend_set = 1'b0;
      in_valid     = 1'b1;
      instr        = mkInstr(DEP, 5'd12, 5'd3, 1'b1, $urandom);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b0 || stall_cnt === 8'd0) begin
         miscompares++; $display("FAIL rst_wait_entry got rdy=%b cnt=%0d want rdy=0 cnt>0", in_ready, stall_cnt);
      end
      #1;
      rst = 1'b0;
      #1;
      vectors++;
      if ({in_ready, out_valid, op_kind, sa, pl, pr, illegal, stall_cnt, sar} !== RESET_WANT) begin
         miscompares++;
         $display("FAIL rst_async got %h want %h",
                  {in_ready, out_valid, op_kind, sa, pl, pr, illegal, stall_cnt, sar}, RESET_WANT);
      end
      @(negedge clk);
      rst       = 1'b1;
      sar_wr    = 1'b1;
      sar_wdata = 5'd5;
      @(negedge clk);
      sar_wr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_no_issue got v=%b rdy=%b want 0 1", out_valid, in_ready);
         end
         @(negedge clk);
      end
      driveIdle();
   endtask

   task automatic test_saturation();
      @(negedge clk);
      sar_pend_set = 1'b1;
      @(negedge clk);
      sar_pend_set = 1'b0;
      in_valid     = 1'b1;
      instr        = mkInstr(DEP, 5'd10, 5'd0, 1'b1, $urandom);
      out_ready    = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (300) @(negedge clk);
      #1;
      vectors++;
      if (stall_cnt !== 8'hFF || in_ready !== 1'b0) begin
         miscompares++; $display("FAIL stall_saturate got cnt=%0d rdy=%b want cnt=255 rdy=0", stall_cnt, in_ready);
      end
      sar_wr    = 1'b1;
      sar_wdata = 5'd4;
      @(negedge clk);
      sar_wr = 1'b0;
      waitOutValid();
      vectors++;
      if ({out_valid, op_kind, sa, pl, pr, stall_cnt} !== {1'b1, 2'd1, 5'd21, 5'd7, 5'd10, 8'hFF}) begin
         miscompares++;
         $display("FAIL saturate_result got v=%b k=%0d sa=%0d pl=%0d pr=%0d cnt=%0d want v=1 k=1 sa=21 pl=7 pr=10 cnt=255",
                  out_valid, op_kind, sa, pl, pr, stall_cnt);
      end
      @(negedge clk);
      driveIdle();
   endtask

   // One randomized cycle, checked against the transaction-level model
   task automatic randomCycle(input bit drain);
      logic [5:0]  op;
      logic [4:0]  pos;
      logic [4:0]  len;
      logic        useSar;
      logic [16:0] want;
      int          r;
      @(negedge clk);
      r = $urandom_range(0, 9);
      op = (r < 3) ? EXTR : (r < 6) ? DEP : (r < 9) ? DSR : 6'($urandom);
      instr        = mkInstr(op, 5'($urandom), 5'($urandom), ($urandom_range(0, 1) == 1), $urandom);
      in_valid     = !drain && ($urandom_range(0, 2) != 0);
      out_ready    = drain || ($urandom_range(0, 3) != 0);
      sar_pend_set = !drain && ($urandom_range(0, 5) == 0);
      sar_wr       = drain || ($urandom_range(0, 4) == 0);
      sar_wdata    = 5'($urandom);
      #1;

      vectors++;
      if (sar !== mSar) begin
         miscompares++; $display("FAIL rand_sar got %0d want %0d", sar, mSar);
      end
      vectors++;
      if (illegal !== mIllegalNext) begin
         miscompares++; $display("FAIL rand_illegal got %b want %b", illegal, mIllegalNext);
      end
      vectors++;
      if (inFlight == 0) begin
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rand_idle got rdy=%b v=%b want 1 0", in_ready, out_valid);
         end
      end else if (in_ready !== (out_valid && out_ready)) begin
         miscompares++;
         $display("FAIL rand_in_ready got %b want %b", in_ready, (out_valid && out_ready));
      end

      if (out_valid === 1'b1 && out_ready) begin
         vectors++;
         if (expQ.size() == 0) begin
            miscompares++; $display("FAIL rand_unexpected_out got k=%0d sa=%0d want none", op_kind, sa);
         end else begin
            want = expQ.pop_front();
            if ({op_kind, sa, pl, pr} !== want) begin
               miscompares++;
               $display("FAIL rand_result got %h want %h", {op_kind, sa, pl, pr}, want);
            end
         end
         if (inFlight > 0) inFlight--;
      end

      mIllegalNext = 1'b0;
      if (in_valid && in_ready === 1'b1) begin
         op     = opOf(instr);
         pos    = field5(instr, 9);
         len    = field5(instr, 14);
         useSar = instr[31-19];
         if (!(op == EXTR || op == DEP || op == DSR)) begin
            mIllegalNext = 1'b1;
         end else begin
            inFlight++;
            if (useSar && mPend && !sar_wr) begin
               mWaiting = 1'b1;
               wOp      = op;
               wPos     = pos;
            end else begin
               expQ.push_back(refResult(op, pos, useSar ? (sar_wr ? sar_wdata : mSar) : len));
            end
         end
      end else if (mWaiting && sar_wr) begin
         expQ.push_back(refResult(wOp, wPos, sar_wdata));
         mWaiting = 1'b0;
      end

      if (sar_wr) begin
         mSar  = sar_wdata;
         mPend = sar_pend_set;
      end else if (sar_pend_set) begin
         mPend = 1'b1;
      end
   endtask

   task automatic test_random();
      applyReset();
      mSar         = '0;
      mPend        = 1'b0;
      mWaiting     = 1'b0;
      mIllegalNext = 1'b0;
      inFlight     = 0;
      expQ.delete();
      for (int i = 0; i < 600; i++) randomCycle(1'b0);
      for (int i = 0; i < 60 && (inFlight != 0 || expQ.size() != 0); i++) randomCycle(1'b1);
      vectors++;
      if (inFlight != 0 || expQ.size() != 0) begin
         miscompares++;
         $display("FAIL rand_drain got inflight=%0d queued=%0d want 0 0", inFlight, expQ.size());
      end
      @(negedge clk);
      driveIdle();
   endtask

   initial begin
      driveIdle();
      test_reset();
      test_extr_latency();
      test_dsr_sar();
      test_stall();
      test_back_to_back();
      test_illegal();
      test_boundaries();
      test_hold_sar_update();
      test_reset_in_wait();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
